// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: round-robin sharing of one compute unit among up to four
// requesters, with request/ready/done sequencing and a grant-to-done watchdog.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_type/req_data   per-requester request (held until gnt)
//   gnt                           one-hot grant pulse, request consumed
//   rsp_valid/rsp_id/rsp_data/rsp_err  one-cycle response to the owner
//   busy                          high whenever the sequencer is not idle
//   cu_unit_id/cu_request/cu_comp_type/cu_data_in  to the compute unit
//   cu_ready/cu_done/cu_result    from the compute unit

package shared_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        COMP_ADD = 2'd0,
        COMP_SUB = 2'd1,
        COMP_MUL = 2'd2,
        COMP_XOR = 2'd3
    } comp_type_e;

    localparam int unsigned COMP_TYPE_W = $bits(comp_type_e);

    // Operand vector: two 16-bit operands, opaque to the arbiter.
    typedef struct packed {
        logic [15:0] op_a;
        logic [15:0] op_b;
    } data_t;

endpackage

module shared_unit_arbiter
    import shared_unit_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = $bits(data_t),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*COMP_TYPE_W-1:0] req_type,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             gnt,
    output logic                         rsp_valid,
    output logic [1:0]                   rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [1:0]                   cu_unit_id,
    output logic                         cu_request,
    input  logic                         cu_ready,
    input  logic                         cu_done,
    output logic [COMP_TYPE_W-1:0]       cu_comp_type,
    output logic [DATA_W-1:0]            cu_data_in,
    input  logic [DATA_W-1:0]            cu_result
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]          wd_q, wd_d;

    logic [N_REQ-1:0]         gnt_d;
    logic                     rsp_valid_d;
    logic [1:0]               rsp_id_d;
    logic [DATA_W-1:0]        rsp_data_d;
    logic                     rsp_err_d;
    logic                     busy_d;
    logic [1:0]               cu_unit_id_d;
    logic                     cu_request_d;
    logic [COMP_TYPE_W-1:0]   cu_comp_type_d;
    logic [DATA_W-1:0]        cu_data_in_d;

    logic [3:0]               req_pad;
    logic [1:0]               cand;
    logic [1:0]               win_idx;
    logic                     win_found;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = req_valid;
        cand                 = '0;
        win_idx              = '0;
        win_found            = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 2'((32'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && req_pad[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        wd_d           = wd_q;
        gnt_d          = '0;
        rsp_valid_d    = 1'b0;
        rsp_id_d       = rsp_id;
        rsp_data_d     = rsp_data;
        rsp_err_d      = rsp_err;
        cu_request_d   = 1'b0;
        cu_unit_id_d   = cu_unit_id;
        cu_comp_type_d = cu_comp_type;
        cu_data_in_d   = cu_data_in;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = ISSUE;
                    gnt_d          = N_REQ'(1) << win_idx;
                    cu_unit_id_d   = win_idx;
                    cu_comp_type_d = req_type[32'(win_idx) * COMP_TYPE_W +: COMP_TYPE_W];
                    cu_data_in_d   = req_data[32'(win_idx) * DATA_W +: DATA_W];
                    cu_request_d   = 1'b1;
                    rr_ptr_d       = 2'((32'(win_idx) + 1) % N_REQ);
                    wd_d           = '0;
                end
            end
            ISSUE: begin
                if (cu_ready) begin
                    state_d = WAIT;
                    // Saturate so a late handshake still leaves WAIT one chance before abort.
                    wd_d    = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;
                end else if (wd_q == WD_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cu_unit_id;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cu_request_d = 1'b1;
                    wd_d         = wd_q + 1'b1;
                end
            end
            WAIT: begin
                // done takes priority over a coincident watchdog expiry
                if (cu_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cu_unit_id;
                    rsp_data_d  = cu_result;
                    rsp_err_d   = 1'b0;
                end else if (wd_q == WD_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cu_unit_id;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            wd_q         <= '0;
            gnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            cu_request   <= 1'b0;
            cu_unit_id   <= '0;
            cu_comp_type <= COMP_ADD;
            cu_data_in   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            wd_q         <= wd_d;
            gnt          <= gnt_d;
            rsp_valid    <= rsp_valid_d;
            rsp_id       <= rsp_id_d;
            rsp_data     <= rsp_data_d;
            rsp_err      <= rsp_err_d;
            busy         <= busy_d;
            cu_request   <= cu_request_d;
            cu_unit_id   <= cu_unit_id_d;
            cu_comp_type <= cu_comp_type_d;
            cu_data_in   <= cu_data_in_d;
        end
    end

endmodule

// File: doc/shared_unit_arbiter.md
# shared_unit_arbiter

Round-robin arbiter and sequencer that shares one `shared_compute_unit` among up to four requesting units. It accepts an operation (computation type plus data vector) from each requester and grants one at a time. It drives the compute unit's request/ready/done handshake and routes the result back to the owner. A watchdog aborts an operation whose `done` never arrives.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, range 2..4; the requester index is carried on the 2-bit `cu_unit_id`.
- `DATA_W`, `$bits(data_t)`: width of the opaque data vector.
- `TIMEOUT`, 1024: cycles allowed from grant to `cu_done` before abort; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request; held high with type/data stable until `gnt` is seen.
- `req_type`  in  N_REQ×comp_type_e  per-requester operation.
- `req_data`  in  N_REQ×DATA_W  per-requester operand vector.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse; the request is consumed this cycle.
- `rsp_valid`  out  1  one-cycle result pulse.
- `rsp_id`  out  2  owner of the current response.
- `rsp_data`  out  DATA_W  result vector; valid with `rsp_valid`.
- `rsp_err`  out  1  set with `rsp_valid` when the operation timed out.
- `busy`  out  1  high in every state except IDLE.
- `cu_unit_id`  out  2  to the compute unit, the owner id.
- `cu_request`  out  1  to the compute unit.
- `cu_ready`  in  1  from the compute unit.
- `cu_done`  in  1  from the compute unit.
- `cu_comp_type`  out  comp_type_e  latched operation.
- `cu_data_in`  out  DATA_W  latched operand.
- `cu_result`  in  DATA_W  from the compute unit; sampled on `cu_done`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - If any `req_valid` is high at the edge, select the winner k.
  - Selection is round-robin: search starts at `rr_ptr` and proceeds upward modulo N_REQ.
  - On selection: latch `req_type[k]`/`req_data[k]` into `cu_comp_type`/`cu_data_in`, set `cu_unit_id`=k, pulse `gnt[k]` in the next cycle, set `rr_ptr`=(k+1) mod N_REQ, clear the watchdog, and go to ISSUE.
- ISSUE: `cu_request`=1. An edge with `cu_ready`=1 moves the FSM to WAIT, and `cu_request` drops.
- WAIT: an edge with `cu_done`=1 captures `cu_result` into `rsp_data`, sets `rsp_err`=0, and moves to RESP.
- Watchdog:
  - It counts every cycle in ISSUE and WAIT.
  - When the count reaches TIMEOUT−1 without the exit condition, go to RESP with `rsp_data`=0 and `rsp_err`=1.
  - `cu_request` is deasserted on abort.
- RESP: `rsp_valid`=1 and `rsp_id`=owner for exactly one cycle, then return to IDLE.
- A `cu_done` arriving in ISSUE is ignored. A `cu_done` arriving in IDLE or RESP (for example, a stale result after a timeout) is ignored and never produces `rsp_valid`.
- Simultaneous `cu_done` and watchdog expiry in WAIT: `done` wins, and `rsp_err`=0.
- Requesters that are not granted keep `req_valid` asserted. There is no queueing inside the block and no request loss.
- `req_valid` bits at or above N_REQ are ignored.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, watchdog=0.
- Outputs at reset: `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `cu_request`=0, `cu_unit_id`=0, `cu_comp_type`=COMP_ADD, `cu_data_in`=0.
- All outputs are registered.
- Edge sequence for the fastest operation:
  - E0: request sampled.
  - Cycle after E0: `gnt` and `cu_request` high.
  - E1: earliest `cu_ready`.
  - E2: earliest `cu_done`.
  - Cycle after E2: `rsp_valid` high.
  - E3: back to IDLE.
  - E4: earliest next grant.
- Minimum interval between grants is 4 cycles when compute latency is 1.
- `cu_comp_type`, `cu_data_in` and `cu_unit_id` are stable from ISSUE through RESP.
- `rst` asserted in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - Any in-flight operation is dropped, with no `rsp_valid`.
  - `rr_ptr` returns to 0.

## Test plan
- Single request: `req_valid`=4'b0010, type COMP_MUL, data D. Expect `gnt`=4'b0010 one cycle later. Expect `cu_unit_id`=1 and `cu_comp_type`=COMP_MUL. With ready and done each after one cycle, expect `rsp_valid` with `rsp_id`=1, `rsp_data`=`cu_result` and `rsp_err`=0, 3 cycles after `gnt`.
- Fairness: all four `req_valid` held high for 8 operations. Expect grant order 0,1,2,3,0,1,2,3 and no requester granted twice before the others.
- Back-pressure: `cu_ready` low for 5 cycles. Expect `cu_request` held high, inputs stable, `busy`=1 and no second grant.
- Timeout: TIMEOUT=8 and `cu_done` never asserted. Expect `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 8 cycles after entering ISSUE. A late `cu_done` in IDLE must produce no response.
- Collision: `cu_done` and watchdog expiry on the same edge. Expect `rsp_err`=0 and captured data.
- Reset mid-WAIT: assert `rst` for one cycle. Expect no `rsp_valid`, all outputs at reset values, and next grant order starting at requester 0.
